// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_seq_pkg
// Purpose : Shared types for the iterative RV32M multiply/divide sequencer.
//           Operation codes follow the RV32M funct3 ordering so the decoder
//           can pass funct3 straight through. Bit 2 set means divide,
//           and for divides bit 1 set selects the remainder.
// Revision: 1.0 - initial release
// ============================================================================
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage : muldiv_seq_pkg
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_seq
// Purpose : Iterative multiply/divide unit for RV32M. Runs XLEN steps of
//           shift-add multiply or restoring divide on operand magnitudes,
//           then applies a sign correction and presents a registered result.
// Ports   : clk      - system clock, rising edge
//           rst      - asynchronous active-high reset
//           start    - launch an operation (ignored while busy)
//           md_code  - operation select (md_op_e encoding)
//           op1/op2  - rs1/rs2 operands, sampled with start
//           flush    - abort whatever is in flight, return to idle
//           busy     - operation in flight, pipeline must stall
//           done     - one-cycle pulse, result valid
//           result   - registered result, held until the next accepted start
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      md_code,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   C_LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement magnitude of a value that may be signed.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                          input logic            is_signed);
    mag = (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  md_state_e         r_state;
  md_state_e         w_next;
  md_op_e            r_code;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_prod;   // multiply: product; divide: low half is dividend/quotient
  logic [XLEN:0]     r_rem;    // divide partial remainder
  logic [XLEN-1:0]   r_mcand;  // multiplicand or divisor magnitude
  logic              r_neg;    // result must be negated in FIX
  logic [XLEN-1:0]   r_result;

  md_op_e            w_op;
  logic              w_accept;
  logic              w_sgn1;
  logic              w_sgn2;
  logic              w_neg1;
  logic              w_neg2;
  logic              w_div0;
  logic              w_ovf;
  logic              w_shortcut;
  logic [XLEN-1:0]   w_short_val;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN+1:0]   w_shift;
  logic [XLEN+1:0]   w_trial;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;

  assign w_op     = md_op_e'(md_code);
  assign w_accept = start && !flush && (r_state == ST_IDLE || r_state == ST_DONE);

  assign w_sgn1 = (w_op == MD_MULH) || (w_op == MD_MULHSU) ||
                  (w_op == MD_DIV)  || (w_op == MD_REM);
  assign w_sgn2 = (w_op == MD_MULH) || (w_op == MD_DIV) || (w_op == MD_REM);
  assign w_neg1 = w_sgn1 && op1[XLEN-1];
  assign w_neg2 = w_sgn2 && op2[XLEN-1];

  // Divide corner cases resolved at accept time without iterating.
  assign w_div0 = md_code[2] && (op2 == '0);
  assign w_ovf  = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                  (op1 == C_INT_MIN) && (op2 == '1);
  assign w_shortcut = w_div0 || w_ovf;

  always_comb begin
    w_short_val = '0;
    if (w_div0) begin
      w_short_val = md_code[1] ? op1 : '1;
    end else if (w_ovf) begin
      w_short_val = md_code[1] ? '0 : C_INT_MIN;
    end
  end

  // Shift-add step: conditionally add multiplicand to the upper half, then
  // shift the whole product right, keeping the carry out of the add.
  assign w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                     (r_prod[0] ? {1'b0, r_mcand} : '0);

  // Restoring step: bring the next dividend bit into the remainder and try
  // subtracting the divisor; the extra top bit flags a negative trial.
  assign w_shift = {r_rem, r_prod[XLEN-1]};
  assign w_trial = w_shift - {2'b00, r_mcand};

  assign w_prod_fix = r_neg ? (~r_prod + 1'b1) : r_prod;
  assign w_quo_fix  = r_neg ? (~r_prod[XLEN-1:0] + 1'b1) : r_prod[XLEN-1:0];
  assign w_rem_fix  = r_neg ? (~r_rem[XLEN-1:0] + 1'b1) : r_rem[XLEN-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            w_next = w_shortcut ? ST_DONE : ST_CALC;
          end else begin
            w_next = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (r_cnt == C_LAST) begin
            w_next = ST_FIX;
          end
        end
        ST_FIX:  w_next = ST_DONE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code   <= MD_MUL;
      r_cnt    <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_mcand  <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_code  <= w_op;
      r_cnt   <= '0;
      r_prod  <= {{XLEN{1'b0}}, mag(op1, w_sgn1)};
      r_rem   <= '0;
      r_mcand <= mag(op2, w_sgn2);
      // Remainder takes the dividend's sign; everything else the XOR.
      r_neg   <= (w_op == MD_REM) ? w_neg1 : (w_neg1 ^ w_neg2);
      if (w_shortcut) begin
        r_result <= w_short_val;
      end
    end else if (r_state == ST_CALC && !flush) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_code[2]) begin
        if (!w_trial[XLEN+1]) begin
          r_rem  <= w_trial[XLEN:0];
          r_prod <= {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-2:0], 1'b1};
        end else begin
          r_rem  <= w_shift[XLEN:0];
          r_prod <= {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-2:0], 1'b0};
        end
      end else begin
        r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
      end
    end else if (r_state == ST_FIX && !flush) begin
      if (r_code[2]) begin
        r_result <= r_code[1] ? w_rem_fix : w_quo_fix;
      end else if (r_code == MD_MUL) begin
        r_result <= w_prod_fix[XLEN-1:0];
      end else begin
        r_result <= w_prod_fix[2*XLEN-1:XLEN];
      end
    end
  end

  assign busy   = (r_state == ST_CALC) || (r_state == ST_FIX);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;

endmodule : muldiv_seq
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_seq
// Purpose : Directed self-checking bench for muldiv_seq: result values,
//           done latency, busy duration, divide shortcuts, flush, ignored
//           and back-to-back starts, asynchronous reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic [2:0]      md_code;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int total;
  int bad;

  muldiv_seq #(.XLEN(XLEN)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .md_code (md_code),
    .op1     (op1),
    .op2     (op2),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation and wait for done. Cycle 1 is the cycle right
  // after the edge that sampled start.
  task automatic run_op(input string tag, input logic [2:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_cyc,
                        input int exp_busy);
    int cyc;
    int bcnt;
    @(negedge clk);
    md_code = c; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op1 = 32'hDEAD_BEEF; op2 = 32'h1234_5678;  // late operand changes must not matter
    cyc = 1; bcnt = 0;
    while (!done && cyc < 60) begin
      bcnt += int'(busy);
      @(posedge clk); #1;
      cyc++;
    end
    check_val({tag, " cycles"}, cyc, exp_cyc);
    check_val({tag, " busy"}, bcnt, exp_busy);
    check_val({tag, " result"}, result, exp);
    @(posedge clk); #1;
    check_val({tag, " done_drop"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int dcnt;
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    md_code = 3'd0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst busy", {31'b0, busy}, 32'd0);
    check_val("rst done", {31'b0, done}, 32'd0);
    check_val("rst result", result, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Main function.
    run_op("MUL",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 33);
    run_op("MULH",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, 33);
    run_op("MULHU",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 33);
    run_op("MULHSU", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 33);
    run_op("DIV",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 33);
    run_op("REM",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 33);
    run_op("DIVU",   3'd5, 32'd100,      32'd7,        32'd14,       34, 33);
    run_op("REMU",   3'd7, 32'd100,      32'd7,        32'd2,        34, 33);

    // Shortcuts.
    run_op("DIVU0",  3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
    run_op("REM0",   3'd6, 32'd5,        32'd0,        32'd5,        1, 0);
    run_op("DIVOVF", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run_op("REMOVF", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0);

    // Flush at cycle 10 of a MUL; result must stay at the previous value (0).
    @(negedge clk);
    md_code = 3'd0; op1 = 32'd9; op2 = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_val("flush pre busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_val("flush busy", {31'b0, busy}, 32'd0);
    check_val("flush done", {31'b0, done}, 32'd0);
    check_val("flush result", result, 32'd0);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      dcnt += int'(done);
    end
    check_val("flush no done", dcnt, 32'd0);

    // Start in CALC ignored, then start in the DONE cycle accepted.
    @(negedge clk);
    md_code = 3'd0; op1 = 32'd3; op2 = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    repeat (4) begin @(posedge clk); #1; cyc++; end
    md_code = 3'd5; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    cyc++;
    start = 1'b0;
    while (!done && cyc < 60) begin @(posedge clk); #1; cyc++; end
    check_val("ign cycles", cyc, 32'd34);
    check_val("ign result", result, 32'd15);
    md_code = 3'd7; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("b2b busy", {31'b0, busy}, 32'd1);
    check_val("b2b done", {31'b0, done}, 32'd0);
    cyc = 1;
    while (!done && cyc < 60) begin @(posedge clk); #1; cyc++; end
    check_val("b2b cycles", cyc, 32'd34);
    check_val("b2b result", result, 32'd2);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    md_code = 3'd5; op1 = 32'd50; op2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_val("arst busy", {31'b0, busy}, 32'd0);
    check_val("arst done", {31'b0, done}, 32'd0);
    check_val("arst result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op("post_rst", 3'd5, 32'd50, 32'd3, 32'd16, 34, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_muldiv_seq
`default_nettype wire
